// File: rtl/seq_pkg.sv
// Shared definitions for the SEQ Y86-64 sequencer: icodes, status codes,
// sequencer states and the memory-access icode classifier.
package seq_pkg;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 3'd4;

   typedef enum logic [2:0] {
      ST_FETCH   = 3'd0,
      ST_DECODE  = 3'd1,
      ST_EXECUTE = 3'd2,
      ST_MEMORY  = 3'd3,
      ST_WRBACK  = 3'd4,
      ST_STOPPED = 3'd5
   } seq_state_e;

   // Instructions that touch data memory and must wait for dmem_ready.
   function automatic logic is_mem_icode(input logic [3:0] ic);
      logic r;
      case (ic)
         I_RMMOVQ, I_MRMOVQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: r = 1'b1;
         default:                                            r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/seq_next_pc.sv
// Combinational next-PC select; shared with the pipelined core.
module seq_next_pc
   import seq_pkg::*;
(
   input  logic [3:0]  icode,
   input  logic        cnd,
   input  logic [63:0] valC,
   input  logic [63:0] valP,
   input  logic [63:0] valM,
   output logic [63:0] new_pc
);

   always_comb begin
      new_pc = valP;
      if (icode == I_CALL) begin
         new_pc = valC;
      end else if (icode == I_JXX && cnd) begin
         new_pc = valC;
      end else if (icode == I_RET) begin
         new_pc = valM;
      end
   end

endmodule

// File: rtl/seq_ctrl.sv
// Multi-cycle SEQ sequencer: PC ownership, one-hot stage enables, status.
// Optional performance counters are built when SEQ_PERF_CNT_EN is defined.
module seq_ctrl
   import seq_pkg::*;
#(
   parameter logic [63:0] RESET_PC    = 64'd0,
   parameter int unsigned MEM_TIMEOUT = 15
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  icode,
   input  logic        instruction_valid,
   input  logic        imem_error,
   input  logic        halt,
   input  logic        cnd,
   input  logic [63:0] valC,
   input  logic [63:0] valP,
   input  logic [63:0] valM,
   input  logic        dmem_ready,
   input  logic        dmem_error,
   output logic [63:0] PC,
   output logic        f_en,
   output logic        d_en,
   output logic        e_en,
   output logic        m_en,
   output logic        w_en,
   output logic [2:0]  stat,
   output logic [63:0] cycle_cnt,
   output logic [63:0] instr_cnt,
   output seq_state_e  dbg_state_o
);

   localparam logic [7:0] TIMER_LAST = 8'(MEM_TIMEOUT - 1);

   seq_state_e  state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic [2:0]  stat_q, stat_d;
   logic [7:0]  timer_q, timer_d;
   logic [63:0] new_pc;

   seq_next_pc u_next_pc (
      .icode  (icode),
      .cnd    (cnd),
      .valC   (valC),
      .valP   (valP),
      .valM   (valM),
      .new_pc (new_pc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_FETCH;
         pc_q    <= RESET_PC;
         stat_q  <= STAT_AOK;
         timer_q <= 8'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         stat_q  <= stat_d;
         timer_q <= timer_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      stat_d  = stat_q;
      timer_d = timer_q;
      case (state_q)
         ST_FETCH: begin
            if (imem_error) begin
               stat_d  = STAT_ADR;
               state_d = ST_STOPPED;
            end else if (!instruction_valid) begin
               stat_d  = STAT_INS;
               state_d = ST_STOPPED;
            end else if (halt) begin
               stat_d  = STAT_HLT;
               state_d = ST_STOPPED;
            end else begin
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: state_d = ST_EXECUTE;
         ST_EXECUTE: begin
            state_d = ST_MEMORY;
            timer_d = 8'd0;
         end
         ST_MEMORY: begin
            // Non-memory icodes pass straight through and ignore dmem_ready.
            if (!is_mem_icode(icode)) begin
               state_d = ST_WRBACK;
            end else if (dmem_ready) begin
               if (dmem_error) begin
                  stat_d  = STAT_ADR;
                  state_d = ST_STOPPED;
               end else begin
                  state_d = ST_WRBACK;
               end
            end else if (timer_q == TIMER_LAST) begin
               stat_d  = STAT_ADR;
               state_d = ST_STOPPED;
            end else begin
               timer_d = timer_q + 8'd1;
            end
         end
         ST_WRBACK: begin
            pc_d    = new_pc;
            state_d = ST_FETCH;
         end
         ST_STOPPED: state_d = ST_STOPPED;
         default:    state_d = ST_STOPPED;
      endcase
   end

   assign f_en        = (state_q == ST_FETCH);
   assign d_en        = (state_q == ST_DECODE);
   assign e_en        = (state_q == ST_EXECUTE);
   assign m_en        = (state_q == ST_MEMORY);
   assign w_en        = (state_q == ST_WRBACK);
   assign PC          = pc_q;
   assign stat        = stat_q;
   assign dbg_state_o = state_q;

`ifdef SEQ_PERF_CNT_EN
   logic [63:0] cycle_cnt_q, cycle_cnt_d;
   logic [63:0] instr_cnt_q, instr_cnt_d;

   assign cycle_cnt_d = (state_q != ST_STOPPED) ? cycle_cnt_q + 64'd1 : cycle_cnt_q;
   assign instr_cnt_d = (state_q == ST_WRBACK)  ? instr_cnt_q + 64'd1 : instr_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_cnt_q <= 64'd0;
         instr_cnt_q <= 64'd0;
      end else begin
         cycle_cnt_q <= cycle_cnt_d;
         instr_cnt_q <= instr_cnt_d;
      end
   end

   assign cycle_cnt = cycle_cnt_q;
   assign instr_cnt = instr_cnt_q;
`else
   assign cycle_cnt = 64'd0;
   assign instr_cnt = 64'd0;
`endif

endmodule

// File: doc/seq_ctrl.md
# seq_ctrl

Multi-cycle sequencer for the SEQ Y86-64 core. It owns the architectural PC and steps each instruction through fetch, decode, execute, memory and write-back by pulsing one stage enable per phase. It then selects the next PC from valP/valC/valM. It also tracks processor status (AOK/HLT/ADR/INS) and stops the core on halt or on any error reported by the fetch or memory stages.

## Interface
- RESET_PC, 64'd0, PC value loaded on reset
- MEM_TIMEOUT, 15, max wait cycles for dmem_ready before an ADR fault (range 1..255)
- clk  input  1  core clock, all state updates on rising edge
- rst_n  input  1  reset; asynchronous, active-low
- icode  input  4  instruction code from fetch, valid in DECODE and later
- instruction_valid  input  1  fetch decode-legal flag
- imem_error  input  1  fetch address fault
- halt  input  1  fetch saw icode 0
- cnd  input  1  condition result from execute, valid in MEMORY and later
- valC, valP, valM  input  64  constant, sequential PC, loaded memory word
- dmem_ready  input  1  data memory access complete
- dmem_error  input  1  data memory fault, sampled with dmem_ready
- PC  output  64  current PC driven to fetch
- f_en, d_en, e_en, m_en, w_en  output  1 each  one-hot stage enables
- stat  output  3  1=AOK, 2=HLT, 3=ADR, 4=INS
- cycle_cnt, instr_cnt  output  64 each  performance counters (see Configuration)

## Operation
- States: FETCH, DECODE, EXECUTE, MEMORY, WRBACK, STOPPED. The stage enable of the current state is high and all others are low. STOPPED drives all enables low.
- FETCH→DECODE normally. Checks at end of FETCH, with priority imem_error > !instruction_valid > halt:
  - imem_error: stat=ADR
  - !instruction_valid: stat=INS
  - halt: stat=HLT
  - Each of these goes to STOPPED, and PC is unchanged.
- DECODE→EXECUTE→MEMORY unconditionally.
- MEMORY, icode in {4,5,8,9,A,B}:
  - Wait for dmem_ready.
  - dmem_ready with dmem_error: stat=ADR, go to STOPPED, no WRBACK.
  - Timer reaching MEM_TIMEOUT without dmem_ready: ADR, STOPPED.
- MEMORY, other icodes: advance after 1 cycle and ignore dmem_ready.
- WRBACK→FETCH. PC loads on the WRBACK clock edge:
  - icode 8 (call): valC
  - icode 7 (jXX) with cnd=1: valC
  - icode 9 (ret): valM
  - otherwise: valP
- STOPPED is terminal and only rst_n leaves it. Inputs are ignored there.
- PC arithmetic is 64-bit. No range check; wrap of valP is the fetch stage's concern.

## Timing
- Reset values: PC=RESET_PC, state FETCH, f_en=1, other enables 0, stat=AOK, counters 0, wait timer 0.
- Non-memory instruction: 5 cycles. Memory instruction: 5 + (cycles until dmem_ready) cycles. dmem_ready in the first MEMORY cycle gives 5 cycles.
- Next-PC is visible the cycle after WRBACK, coinciding with f_en.
- Faults are flagged at the edge ending the faulting state. stat updates and enables drop to 0 on that same edge.
- A rst_n assertion mid-instruction asynchronously forces reset values. No partial write-back is signalled because w_en drops immediately.
- The wait timer clears on entering MEMORY.

## Configuration
- SEQ_PERF_CNT_EN defined:
  - cycle_cnt increments every cycle while not STOPPED.
  - instr_cnt increments on each WRBACK exit.
  - Both wrap modulo 2^64.
- Not defined: both outputs are constant 0 and no counter flops are built.

## Structure
- Package seq_pkg holds:
  - icode localparams (I_HALT=0 … I_POPQ=B)
  - stat codes
  - the state enum
  - the memory-icode membership function
- One sub-module, seq_next_pc: combinational next-PC mux (icode, cnd, valC, valP, valM → new_pc). It is reused later by the pipelined core.

## Test plan
- irmovq (icode 3, valP=10) from PC 0 → f_en,d_en,e_en,m_en,w_en pulse on cycles 0-4, PC=10 on cycle 5, stat=1.
- jXX at PC 10 with cnd=1, valC=0x40 → PC=0x40. Repeat with cnd=0, valP=19 → PC=19.
- mrmovq with dmem_ready after 3 waits → instruction takes 8 cycles. ret with valM=0x100 → PC=0x100.
- dmem_ready never asserted, MEM_TIMEOUT=15 → stat=3 after 15 MEMORY cycles, enables 0, PC unchanged.
- halt at PC 0x20 → stat=2, PC stays 0x20, STOPPED. imem_error together with !instruction_valid → stat=3.
- rst_n low during EXECUTE → immediate PC=RESET_PC, f_en=1, stat=1. With SEQ_PERF_CNT_EN, counters read 0 after reset and instr_cnt=3 after 3 nops.
